// File: rtl/lattice_result_collector.sv
// lattice_result_collector: tail-end receiver for the lattice core chain.
// Registers the per-core result stream, counts one report per core per round,
// pulses round_done/round_found at round end, and queues nonce-found reports
// in a small FIFO drained over a valid/ready handshake. Drops on a full FIFO
// raise a sticky overflow flag.
module lattice_result_collector #(
   parameter  int LOG2_NUM_CORES  = 1,
   parameter  int NONCE_W         = 32,
   parameter  int LOG2_FIFO_DEPTH = 2,
   localparam int IDX_W           = (LOG2_NUM_CORES > 0) ? LOG2_NUM_CORES : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               res_valid,
   input  logic               res_success,
   input  logic [IDX_W-1:0]   res_index,
   input  logic [NONCE_W-1:0] res_nonce,
   input  logic               clear,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [IDX_W-1:0]   out_index,
   output logic [NONCE_W-1:0] out_nonce,
   output logic               round_done,
   output logic               round_found,
   output logic               overflow
);

   localparam int NUM_CORES = 1 << LOG2_NUM_CORES;
   localparam int DEPTH     = 1 << LOG2_FIFO_DEPTH;
   localparam int CNT_W     = LOG2_NUM_CORES + 1;
   localparam int PTR_W     = (LOG2_FIFO_DEPTH > 0) ? LOG2_FIFO_DEPTH : 1;
   localparam int OCC_W     = LOG2_FIFO_DEPTH + 1;
   localparam int ENTRY_W   = IDX_W + NONCE_W;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_e;

   // ---------------------------------------------------------------------
   // Capture stage
   // ---------------------------------------------------------------------
   logic               cap_valid_d,   cap_valid_q;
   logic               cap_success_d, cap_success_q;
   logic [IDX_W-1:0]   cap_index_d,   cap_index_q;
   logic [NONCE_W-1:0] cap_nonce_d,   cap_nonce_q;
   logic               cap_hit;

   // Next value of the capture registers; clear flushes a report in flight.
   always_comb begin
      cap_valid_d   = res_valid;
      cap_success_d = res_valid & res_success;
      cap_index_d   = res_index;
      cap_nonce_d   = res_nonce;
      if (clear) begin
         cap_valid_d   = 1'b0;
         cap_success_d = 1'b0;
         cap_index_d   = '0;
         cap_nonce_d   = '0;
      end
   end

   // Capture registers; every decision below works on this copy.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples its _d value from before the edge regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_valid_q   <= 1'b0;
         cap_success_q <= 1'b0;
         cap_index_q   <= '0;
         cap_nonce_q   <= '0;
      end else begin
         cap_valid_q   <= cap_valid_d;
         cap_success_q <= cap_success_d;
         cap_index_q   <= cap_index_d;
         cap_nonce_q   <= cap_nonce_d;
      end
   end

   assign cap_hit = cap_valid_q & cap_success_q;

   // ---------------------------------------------------------------------
   // Round tracking FSM
   // ---------------------------------------------------------------------
   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic             found_q;
   logic             round_done_q;
   logic             round_found_q;

   // Round FSM: counts reports, pulses round_done for the single DONE cycle.
   // A report seen in DONE opens the next round, so none is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         count_q       <= '0;
         found_q       <= 1'b0;
         round_done_q  <= 1'b0;
         round_found_q <= 1'b0;
      end else if (clear) begin
         state_q       <= IDLE;
         count_q       <= '0;
         found_q       <= 1'b0;
         round_done_q  <= 1'b0;
         round_found_q <= 1'b0;
      end else begin
         round_done_q  <= 1'b0;
         round_found_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (cap_valid_q) begin
                  found_q <= found_q | cap_hit;
                  if (count_q == CNT_W'(NUM_CORES - 1)) begin
                     state_q       <= DONE;
                     count_q       <= '0;
                     round_done_q  <= 1'b1;
                     round_found_q <= found_q | cap_hit;
                  end else begin
                     count_q <= count_q + CNT_W'(1);
                  end
               end
            end
            // IDLE and DONE both treat a report as the first of a new round;
            // found is always 0 in IDLE, so restarting it from cap_hit is
            // also the clear-on-exit-from-DONE rule.
            default: begin
               found_q <= cap_hit;
               if (cap_valid_q) begin
                  if (NUM_CORES == 1) begin
                     state_q       <= DONE;
                     count_q       <= '0;
                     round_done_q  <= 1'b1;
                     round_found_q <= cap_hit;
                  end else begin
                     state_q <= COLLECT;
                     count_q <= CNT_W'(1);
                  end
               end else begin
                  state_q <= IDLE;
                  count_q <= '0;
               end
            end
         endcase
      end
   end

   assign round_done  = round_done_q;
   assign round_found = round_found_q;

   // ---------------------------------------------------------------------
   // Success FIFO
   // ---------------------------------------------------------------------
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_d, wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_d, rd_ptr_q;
   logic [OCC_W-1:0]   occ_d,    occ_q;
   logic               overflow_d, overflow_q;
   logic               full;
   logic               pop;
   logic               wr_en;
   logic [ENTRY_W-1:0] head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (occ_q == OCC_W'(DEPTH));
   assign pop   = out_valid & out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en = cap_hit & (~full | pop) & ~clear;

   // FIFO pointer/occupancy/overflow next state; clear overrides push and pop.
   // NOTE: every variable gets a default at the top of the always_comb so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      overflow_d = overflow_q;
      if (clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         occ_d      = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({wr_en, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
         if (cap_hit && full && !pop) overflow_d = 1'b1;
      end
   end

   // FIFO control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage write.
   // NOTE: the storage array has no reset; occupancy alone decides which
   // entries are meaningful, so resetting the data would only cost flops.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {cap_index_q, cap_nonce_q};
   end

   // Head is read straight from storage: stable while not popped, no bypass.
   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (occ_q != '0);
   assign out_index = head[ENTRY_W-1:NONCE_W];
   assign out_nonce = head[NONCE_W-1:0];
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_lattice_result_collector.sv
// Directed self-checking bench for lattice_result_collector with the default
// parameters: 2 cores, 32-bit nonces, 4-entry success FIFO.
module tb_lattice_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic        res_success;
   logic [0:0]  res_index;
   logic [31:0] res_nonce;
   logic        clear;
   logic        out_valid;
   logic        out_ready;
   logic [0:0]  out_index;
   logic [31:0] out_nonce;
   logic        round_done;
   logic        round_found;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   lattice_result_collector #(
      .LOG2_NUM_CORES (1),
      .NONCE_W        (32),
      .LOG2_FIFO_DEPTH(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .res_valid  (res_valid),
      .res_success(res_success),
      .res_index  (res_index),
      .res_nonce  (res_nonce),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_nonce  (out_nonce),
      .round_done (round_done),
      .round_found(round_found),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one report for one cycle, then return the chain to idle.
   task automatic send(input logic s, input logic [0:0] idx, input logic [31:0] n);
      res_valid   = 1'b1;
      res_success = s;
      res_index   = idx;
      res_nonce   = n;
      tick();
      res_valid   = 1'b0;
      res_success = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      checks++; if (round_done !== 1'b0)  begin errors++; $display("FAIL rst_round_done: got %b want 0", round_done); end
      checks++; if (round_found !== 1'b0) begin errors++; $display("FAIL rst_round_found: got %b want 0", round_found); end
      checks++; if (overflow !== 1'b0)    begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_no_success();
      out_ready = 1'b1;
      send(1'b0, 1'b0, 32'h0);
      send(1'b0, 1'b1, 32'h0);
      checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL nosucc_early_done: got %b want 0", round_done); end
      tick();
      checks++; if (round_done !== 1'b1)  begin errors++; $display("FAIL nosucc_done: got %b want 1", round_done); end
      checks++; if (round_found !== 1'b0) begin errors++; $display("FAIL nosucc_found: got %b want 0", round_found); end
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL nosucc_out_valid: got %b want 0", out_valid); end
      tick();
      checks++; if (round_done !== 1'b0) begin errors++; $display("FAIL nosucc_pulse_width: got %b want 0", round_done); end
   endtask

   task automatic test_success();
      out_ready = 1'b1;
      send(1'b1, 1'b1, 32'hDEADBEEF);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL succ_no_bypass: got %b want 0", out_valid); end
      send(1'b0, 1'b0, 32'h0);
      checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL succ_out_valid: got %b want 1", out_valid); end
      checks++; if (out_index !== 1'b1)        begin errors++; $display("FAIL succ_out_index: got %0d want 1", out_index); end
      checks++; if (out_nonce !== 32'hDEADBEEF) begin errors++; $display("FAIL succ_out_nonce: got %h want deadbeef", out_nonce); end
      tick();
      checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL succ_popped: got %b want 0", out_valid); end
      checks++; if (round_done !== 1'b1)  begin errors++; $display("FAIL succ_done: got %b want 1", round_done); end
      checks++; if (round_found !== 1'b1) begin errors++; $display("FAIL succ_found: got %b want 1", round_found); end
   endtask

   task automatic test_overflow();
      do_clear();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send(1'b1, 1'(k % 2), 32'(k));
      // Fourth success now stored, fifth still in the capture stage.
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      checks++; if (out_nonce !== 32'd1) begin errors++; $display("FAIL ovf_hold_nonce: got %0d want 1", out_nonce); end
      tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      tick();
      checks++; if (out_nonce !== 32'd1) begin errors++; $display("FAIL ovf_hold_nonce2: got %0d want 1", out_nonce); end
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL ovf_drain_valid%0d: got %b want 1", k, out_valid); end
         checks++; if (out_nonce !== 32'(k))   begin errors++; $display("FAIL ovf_drain_nonce%0d: got %0d want %0d", k, out_nonce, k); end
         checks++; if (out_index !== 1'(k % 2)) begin errors++; $display("FAIL ovf_drain_index%0d: got %0d want %0d", k, out_index, k % 2); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] exp_n [4];
      exp_n = '{32'd11, 32'd12, 32'd13, 32'd14};
      do_clear();
      out_ready = 1'b0;
      for (int k = 10; k <= 13; k++) send(1'b1, 1'b0, 32'(k));
      tick();
      // FIFO full; the next success sits in capture while the head pops.
      send(1'b1, 1'b1, 32'd14);
      out_ready = 1'b1;
      tick();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_no_overflow: got %b want 0", overflow); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL fpp_valid%0d: got %b want 1", k, out_valid); end
         checks++; if (out_nonce !== exp_n[k]) begin errors++; $display("FAIL fpp_nonce%0d: got %0d want %0d", k, out_nonce, exp_n[k]); end
         tick();
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty: got %b want 0", out_valid); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fpp_overflow_end: got %b want 0", overflow); end
   endtask

   task automatic test_back_to_back();
      logic want;
      do_clear();
      out_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         res_valid   = (k <= 6);
         res_success = 1'b0;
         tick();
         want = (k == 3) || (k == 5) || (k == 7);
         checks++; if (round_done !== want) begin errors++; $display("FAIL b2b_done_t%0d: got %b want %b", k, round_done, want); end
      end
      res_valid = 1'b0;
   endtask

   task automatic test_clear();
      int pulses;
      int pulse_at;
      do_clear();
      out_ready = 1'b0;
      for (int k = 21; k <= 25; k++) send(1'b1, 1'b0, 32'(k));
      tick();
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      // Two entries left, overflow set, round count at 1.
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_pre_valid: got %b want 1", out_valid); end
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL clr_pre_overflow: got %b want 1", overflow); end
      do_clear();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clr_out_valid: got %b want 0", out_valid); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL clr_overflow: got %b want 0", overflow); end
      pulses   = 0;
      pulse_at = -1;
      send(1'b0, 1'b0, 32'h0);
      if (round_done === 1'b1) begin pulses++; pulse_at = 1; end
      send(1'b0, 1'b1, 32'h0);
      if (round_done === 1'b1) begin pulses++; pulse_at = 2; end
      for (int k = 3; k <= 6; k++) begin
         tick();
         if (round_done === 1'b1) begin pulses++; pulse_at = k; end
      end
      checks++; if (pulses !== 1)   begin errors++; $display("FAIL clr_pulse_count: got %0d want 1", pulses); end
      checks++; if (pulse_at !== 3) begin errors++; $display("FAIL clr_pulse_time: got %0d want 3", pulse_at); end
   endtask

   task automatic test_reset_mid();
      do_clear();
      out_ready = 1'b0;
      send(1'b1, 1'b1, 32'h55);
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b want 0", out_valid); end
      tick();
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid: got %b want 0", out_valid); end
   endtask

   initial begin
      rst         = 1'b1;
      res_valid   = 1'b0;
      res_success = 1'b0;
      res_index   = '0;
      res_nonce   = '0;
      clear       = 1'b0;
      out_ready   = 1'b0;
      test_reset();
      test_no_success();
      test_success();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lattice_result_collector.md
Name: lattice_result_collector

Overview:
- Tail-end receiver for the lattice core chain. Consumes the per-core result stream that leaves the last lattice stage.
- Counts one report per core per round and signals round completion.
- Buffers successful (nonce-found) reports in a small FIFO and hands them to the host side over a valid/ready handshake.
- Flags buffer overflow stickily.

Parameters:
- LOG2_NUM_CORES, 1, log2 of number of cores in the chain; reports per round = 2**LOG2_NUM_CORES
- NONCE_W, 32, width of the nonce carried with each report
- LOG2_FIFO_DEPTH, 2, log2 of success FIFO depth (depth = 2**LOG2_FIFO_DEPTH, minimum 1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- res_valid  in  1  chain output carries a core report this cycle
- res_success  in  1  reporting core found a valid nonce; qualified by res_valid
- res_index  in  LOG2_NUM_CORES  index of reporting core
- res_nonce  in  NONCE_W  nonce from reporting core
- clear  in  1  synchronous clear of round counter, FIFO and overflow
- out_valid  out  1  FIFO head is presented on out_index/out_nonce
- out_ready  in  1  host accepts head when out_valid && out_ready
- out_index  out  LOG2_NUM_CORES  core index of head entry
- out_nonce  out  NONCE_W  nonce of head entry
- round_done  out  1  one-cycle pulse: all cores reported for current round
- round_found  out  1  valid with round_done; 1 if any report in that round had res_success
- overflow  out  1  sticky; a success was dropped because the FIFO was full

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, round count 0, FSM = IDLE, found flag 0.
- Input stage: res_* are registered once (capture stage). All decisions below act on the registered copy (cap_*), one cycle after the chain edge.
- FSM states:
  - IDLE: no report yet in round. cap_valid -> COLLECT, count = 1. If NUM_CORES = 1, go directly to DONE.
  - COLLECT: each cap_valid increments count. When cap_valid && count == NUM_CORES-1 -> DONE, count wraps to 0.
  - DONE: round_done = 1 for exactly this cycle, round_found = OR of cap_success over the round. Always -> IDLE next cycle.
  - A cap_valid arriving while in DONE counts as the first report of the next round: -> COLLECT, count = 1. No report is lost.
- Found flag: set by cap_valid && cap_success. Cleared on entry to IDLE/COLLECT from DONE, except it is set again if the report in DONE itself was a success.
- Round counter is LOG2_NUM_CORES+1 bits wide. Count never exceeds NUM_CORES-1 outside DONE.
- FIFO push: cap_valid && cap_success. The entry is {cap_index, cap_nonce}.
- FIFO pop: out_valid && out_ready.
- FIFO full + push, no pop: entry dropped, overflow <= 1. overflow stays 1 until rst or clear.
- FIFO full + push + pop in same cycle: both occur; occupancy unchanged; no overflow.
- FIFO empty + push + pop: no pop is possible, since out_valid = 0.
- Latency: a success report at the chain inputs on edge t gives out_valid = 1 after edge t+2 when the FIFO was empty (first-word presented from storage, no bypass).
- Output hold: while out_valid && !out_ready, out_index and out_nonce are stable.
- out_index and out_nonce hold their last value when out_valid = 0 (don't-care for checking).
- clear: synchronous, one cycle.
  - Empties the FIFO (out_valid = 0 next cycle), count = 0, FSM = IDLE, found = 0, overflow = 0.
  - Overrides a same-cycle push, pop or round completion. No round_done fires that cycle.
  - The capture stage is also cleared.
- rst mid-round or mid-handshake: everything returns to reset values immediately. A pending out_valid is dropped.
- Occupancy counter is LOG2_FIFO_DEPTH+1 bits. Read and write pointers wrap modulo depth.

Test Plan:
- NUM_CORES=2. Two consecutive res_valid, both res_success=0 -> round_done pulse 2 cycles after the second report, round_found=0, out_valid stays 0.
- NUM_CORES=2. Reports (index 1, nonce 0xDEADBEEF, success=1) then (index 0, success=0), out_ready=1 -> out_valid 2 cycles after the first report with out_index=1 and out_nonce=0xDEADBEEF for one cycle. round_done with round_found=1.
- Depth 4, out_ready=0. Five successive successes (nonces 1..5) -> overflow=1 after the fifth is captured. Then out_ready=1 drains nonces 1,2,3,4 in order, and overflow stays 1.
- FIFO full, out_ready=1, new success arrives in the same cycle as a pop -> no overflow, occupancy stays 4, new nonce appears last in the drain order.
- Back-to-back rounds: res_valid held high for 6 cycles with NUM_CORES=2 -> three round_done pulses, each 2 cycles apart, and no dropped count.
- clear asserted mid-round (count=1) with 2 FIFO entries and overflow=1 -> next cycle out_valid=0, overflow=0. The following two reports produce exactly one round_done.
